// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared types and constants for the nibble-serial adder
//
// Purpose: FSM state encoding and slice width used by nibble_serial_add_ctrl.
// Ports: none (package).
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } nas_state_t;

endpackage

// File: rtl/FullAdder_4bit.sv
// rtl/FullAdder_4bit.sv - 4-bit carry-lookahead adder slice
//
// Purpose: combinational 4-bit add with all carries computed from
//          generate/propagate terms rather than rippled.
// Ports:
//   a_i, b_i  in  4  operand nibbles
//   c_i       in  1  carry-in
//   s_o       out 4  sum nibble
//   c_o       out 1  lookahead carry-out
module FullAdder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_i);
        s_o  = p ^ c[3:0];
        c_o  = c[4];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial WIDTH-bit adder sequencer
//
// Purpose: time-shares one FullAdder_4bit slice to add two WIDTH-bit operands,
//          one nibble per clock LSB first, with a registered inter-nibble carry.
// Optional: macro NIBBLE_ADD_SUB_EN adds input 'sub' (a - b when set at accept).
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands valid
//   in_ready   out 1      operands accepted this cycle when in_valid is high
//   a_in, b_in in  WIDTH  operands
//   c_in       in  1      carry-in for nibble 0
//   sub        in  1      (NIBBLE_ADD_SUB_EN only) subtract request
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  registered result
//   c_out      out 1      carry out of the top nibble (1 = no borrow when subtracting)
//   busy       out 1      operation in flight (RUN or DONE)
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    nas_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic [WIDTH-1:0]    b_cap;
    logic                carry_cap;

    FullAdder_4bit u_slice (
        .a_i (a_sh_q[NIBBLE_W-1:0]),
        .b_i (b_sh_q[NIBBLE_W-1:0]),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // Subtraction is a + ~b + 1: invert b at capture and force the carry-in.
`ifdef NIBBLE_ADD_SUB_EN
    assign b_cap     = sub ? ~b_in : b_in;
    assign carry_cap = sub ? 1'b1 : c_in;
`else
    assign b_cap     = b_in;
    assign carry_cap = c_in;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Both registers are frozen in DONE, so the result cannot glitch.
    assign sum       = sum_sh_q;
    assign c_out     = carry_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_cap;
                    carry_d = carry_cap;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Nibbles enter at the MSB end so after NIBBLES shifts the
                // first (least significant) nibble lands at bit 0.
                sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:NIBBLE_W]};
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                carry_d  = slice_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
//
// Purpose: directed and randomized operand streams checked against a
//          transaction-level model; NIBBLE_ADD_SUB_EN enables subtract cases.
// Ports: none (top-level bench).
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, busy;
    logic [W-1:0]  a_in, b_in, sum;

    logic          in_valid8, in_ready8, c_in8, out_valid8, out_ready8, c_out8, busy8;
    logic [7:0]    a8, b8, sum8;
    logic          sub8;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
`ifdef NIBBLE_ADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .busy(busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a8), .b_in(b8), .c_in(c_in8),
`ifdef NIBBLE_ADD_SUB_EN
        .sub(sub8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
        .c_out(c_out8), .busy(busy8)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one pending result, visible NIBBLES edges
    // after the accept edge, retired by an out_ready handshake.
    longint     cyc = 0;
    longint     done_cyc = 0;
    bit         pending = 0;
    logic [W:0] m_res;
    longint     acc_q[$];
    int         n_hs = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pending = 0;
        end else if (!pending) begin
            if (in_valid) begin
                pending = 1;
                if (sub === 1'b1)
                    m_res = {1'b0, a_in} + {1'b0, ~b_in} + (W+1)'(1);
                else
                    m_res = {1'b0, a_in} + {1'b0, b_in} + (W+1)'(c_in);
                done_cyc = cyc + N;
                acc_q.push_back(cyc);
            end
        end else if ((cyc - 1) >= done_cyc && out_ready) begin
            pending = 0;
            n_hs++;
        end
    end

    always @(negedge clk) begin
        bit exp_ov;
        exp_ov = pending && (cyc >= done_cyc);
        check("out_valid", out_valid, exp_ov);
        check("busy", busy, pending);
        check("in_ready", in_ready, !pending && !rst);
        if (exp_ov) begin
            check("sum", sum, m_res[W-1:0]);
            check("c_out", c_out, m_res[W]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ov(input string name);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (out_valid !== 1'b1) check({name, "_timeout"}, out_valid, 1);
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 1; a_in = 0; b_in = 0; c_in = 0; sub = 0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; c_in8 = 0; sub8 = 0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();

        // Overflow wrap, latency and single-cycle out_valid.
        send(16'hFFFF, 16'h0001, 1'b0);
        repeat (N - 1) tick();
        check("t1_lat_lo", out_valid, 0);
        tick();
        check("t1_lat_hi", out_valid, 1);
        check("t1_sum", sum, 16'h0000);
        check("t1_c_out", c_out, 1);
        tick();
        check("t1_one_cycle", out_valid, 0);

        // in_valid held high: accepts spaced by NIBBLES+2.
        acc_q.delete();
        a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b1; in_valid = 1'b1;
        repeat (N + 1) tick();
        check("t2_sum", sum, 16'h5556);
        check("t2_c_out", c_out, 0);
        repeat (8) tick();
        in_valid = 1'b0;
        check("t2_accepts", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) check("t2_interval", 32'(acc_q[1] - acc_q[0]), N + 2);
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0);
        wait_ov("t3");
        for (int i = 0; i < 3; i++) begin
            check("t3_sum_hold", sum, 16'h0000);
            check("t3_c_hold", c_out, 1);
            check("t3_in_ready", in_ready, 0);
            check("t3_ov_hold", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t3_release_ov", out_valid, 0);
        check("t3_release_idle", in_ready, 1);

        // Reset on the second RUN cycle.
        send(16'h00FF, 16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("t4_ov", out_valid, 0);
        check("t4_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("t4_in_ready", in_ready, 1);
        tick();
        send(16'h0001, 16'h0002, 1'b0);
        wait_ov("t4b");
        check("t4_sum", sum, 16'h0003);
        drain();

        // WIDTH = 8 instance.
        a8 = 8'hF0; b8 = 8'h20; c_in8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        check("w8_lat_lo", out_valid8, 0);
        tick();
        check("w8_lat_hi", out_valid8, 1);
        check("w8_sum", sum8, 8'h10);
        check("w8_c_out", c_out8, 1);
        tick();

`ifdef NIBBLE_ADD_SUB_EN
        sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b0);
        wait_ov("sub1");
        check("sub1_sum", sum, 16'hFFFE);
        check("sub1_c", c_out, 0);
        drain();
        send(16'h0007, 16'h0005, 1'b0);
        wait_ov("sub2");
        check("sub2_sum", sum, 16'h0002);
        check("sub2_c", c_out, 1);
        drain();
        sub = 1'b0;
`endif

        // Randomized traffic with backpressure and occasional reset.
        n_hs = 0;
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            a_in      = 16'($urandom);
            b_in      = 16'($urandom);
            c_in      = 1'($urandom);
`ifdef NIBBLE_ADD_SUB_EN
            sub       = 1'($urandom);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        sub = 1'b0;
        drain();
        check("rand_handshakes", n_hs > 50, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
